// File: rtl/muldiv_seq32.sv
// muldiv_seq32: multi-cycle 32-bit multiply/divide sequencer.
// Radix-2 shift-and-add multiply and restoring divide share one adder.
// Fixed latency of 34 cycles from an accepted start to the DONE cycle.
// Optional feature macro: MULDIV_SIGNED_EN enables signed MULS/DIVS (op[1]).
module muldiv_seq32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] resHi,
  output logic [31:0] resLo,
  output logic        divZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;      // MUL: upper product; DIV: remainder
  logic [31:0] lo_q, lo_d;        // MUL: multiplier/low product; DIV: dividend/quotient
  logic [31:0] opnd_q, opnd_d;    // MUL: multiplicand; DIV: divisor
  logic [31:0] a_raw_q, a_raw_d;  // original A, returned as remainder on divide by zero
  logic        is_div_q, is_div_d;
  logic        bzero_q, bzero_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        div_zero_q, div_zero_d;

  logic        in_sgn_s;
  logic [31:0] a_abs_s, b_abs_s;
  logic [32:0] add_a_s, add_b_s;
  logic        add_cin_s;
  logic [33:0] sum_s;
  logic [31:0] fix_hi_s, fix_lo_s;
  logic        fix_dz_s;

`ifdef MULDIV_SIGNED_EN
  logic        sgn_q, sgn_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        ovf_q, ovf_d;
  logic [63:0] prod_neg_s;

  assign in_sgn_s   = op[1];
  assign a_abs_s    = (in_sgn_s && A[31]) ? (~A + 32'd1) : A;
  assign b_abs_s    = (in_sgn_s && B[31]) ? (~B + 32'd1) : B;
  assign prod_neg_s = ~{acc_q, lo_q} + 64'd1;
`else
  logic unused_op1_s;
  assign unused_op1_s = op[1];
  assign in_sgn_s     = 1'b0;
  assign a_abs_s      = A;
  assign b_abs_s      = B;
`endif

  // Shared adder: adds the multiplicand for MUL, subtracts the divisor for DIV.
  always_comb begin
    add_a_s   = is_div_q ? {acc_q, lo_q[31]} : {1'b0, acc_q};
    add_b_s   = is_div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    add_cin_s = is_div_q;
    sum_s     = {1'b0, add_a_s} + {1'b0, add_b_s} + {33'd0, add_cin_s};
  end

  // Result correction: sign fix-ups first, then divide-by-zero / overflow overrides.
  always_comb begin
    fix_hi_s = acc_q;
    fix_lo_s = lo_q;
    fix_dz_s = 1'b0;
`ifdef MULDIV_SIGNED_EN
    if (sgn_q && !is_div_q && (sign_a_q ^ sign_b_q)) begin
      fix_hi_s = prod_neg_s[63:32];
      fix_lo_s = prod_neg_s[31:0];
    end else if (sgn_q && is_div_q) begin
      fix_lo_s = (sign_a_q ^ sign_b_q) ? (~lo_q + 32'd1) : lo_q;
      fix_hi_s = sign_a_q ? (~acc_q + 32'd1) : acc_q;
    end else begin
      fix_hi_s = acc_q;
    end
`endif
    if (is_div_q && bzero_q) begin
      fix_lo_s = 32'hFFFF_FFFF;
      fix_hi_s = a_raw_q;
      fix_dz_s = 1'b1;
`ifdef MULDIV_SIGNED_EN
    end else if (ovf_q) begin
      fix_lo_s = 32'h8000_0000;
      fix_hi_s = 32'h0000_0000;
`endif
    end else begin
      fix_dz_s = 1'b0;
    end
  end

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    bzero_d    = bzero_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
`ifdef MULDIV_SIGNED_EN
    sgn_d      = sgn_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = 5'd31;
          acc_d    = 32'd0;
          is_div_d = op[0];
          a_raw_d  = A;
          bzero_d  = (B == 32'd0);
          lo_d     = op[0] ? a_abs_s : b_abs_s;
          opnd_d   = op[0] ? b_abs_s : a_abs_s;
`ifdef MULDIV_SIGNED_EN
          sgn_d    = in_sgn_s;
          sign_a_d = in_sgn_s & A[31];
          sign_b_d = in_sgn_s & B[31];
          ovf_d    = in_sgn_s & op[0] & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (sum_s[33]) begin
            acc_d = sum_s[31:0];
            lo_d  = {lo_q[30:0], 1'b1};
          end else begin
            acc_d = add_a_s[31:0];
            lo_d  = {lo_q[30:0], 1'b0};
          end
        end else begin
          if (lo_q[0]) begin
            acc_d = sum_s[32:1];
            lo_d  = {sum_s[0], lo_q[31:1]};
          end else begin
            acc_d = {1'b0, acc_q[31:1]};
            lo_d  = {acc_q[0], lo_q[31:1]};
          end
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        res_hi_d   = fix_hi_s;
        res_lo_d   = fix_lo_s;
        div_zero_d = fix_dz_s;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 32'd0;
      lo_q       <= 32'd0;
      opnd_q     <= 32'd0;
      a_raw_q    <= 32'd0;
      is_div_q   <= 1'b0;
      bzero_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_hi_q   <= 32'd0;
      res_lo_q   <= 32'd0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      bzero_q    <= bzero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q      <= sgn_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign resHi   = res_hi_q;
  assign resLo   = res_lo_q;
  assign divZero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq32.sv
// Directed self-checking bench for muldiv_seq32 (both MULDIV_SIGNED_EN builds).
module tb_muldiv_seq32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, divZero;
  logic [31:0] resHi, resLo;

  int checks   = 0;
  int failures = 0;

  muldiv_seq32 dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .resHi(resHi), .resLo(resLo), .divZero(divZero)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and track busy/done/results over its 34-cycle life.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input bit pulses);
    int done_cnt;
    int busy_bad;
    done_cnt = 0;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; A = ~a; B = b + 32'd3;
    for (int k = 1; k <= 34; k++) begin
      if (pulses && (k == 5 || k == 20)) start = 1'b1;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        check_eq({name, "_done_cycle"}, 64'(k), 64'd34);
      end
      if (k == 34) begin
        check_eq({name, "_resHi"}, {32'd0, resHi}, {32'd0, eh});
        check_eq({name, "_resLo"}, {32'd0, resLo}, {32'd0, el});
        check_eq({name, "_divZero"}, {63'd0, divZero}, {63'd0, ed});
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq({name, "_busy_bad_cycles"}, 64'(busy_bad), 64'd0);
    check_eq({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_eq({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    check_eq({name, "_done_after"}, {63'd0, done}, 64'd0);
    check_eq({name, "_hold"}, {resHi, resLo}, {eh, el});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_res", {resHi, resLo}, 64'd0);
    check_eq("rst_divZero", {63'd0, divZero}, 64'd0);
    rst = 1'b0;

    run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mulu_shift", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0);
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    run_op("divu_small", 2'b01, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 1'b0);
    run_op("divu_by1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_by0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("divs_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("muls_m3_7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("divs_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
`else
    run_op("muls_m3_7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("divs_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 1'b0);
    run_op("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
`endif

    // Abort a MULU at cycle 10 with reset.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_res", {resHi, resLo}, 64'd0);
    check_eq("abort_divZero", {63'd0, divZero}, 64'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", 64'(dcount), 64'd0);
    run_op("mulu_after_abort", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

    // Reset and start in the same cycle: start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_busy0", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check_eq("rst_start_busy1", {63'd0, busy}, 64'd0);
    check_eq("rst_start_res", {resHi, resLo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
